// File: rtl/dsp_uart_tx.sv
// dsp_uart_tx: bus-fed console output; buffers bytes in a small FIFO and shifts them out as 8N1 UART frames.
// Optional macro DSP_UART_PARITY_EN inserts an even-parity bit before STOP (8E1 frames).
module dsp_uart_tx #(
    parameter int CLK_DIV = 16,
    parameter int FIFO_AW = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        in,
    input  logic               dsp_in_en,
    input  logic               ovf_clr,
    output logic               tx,
    output logic               busy,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               overflow
);
    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = $clog2(CLK_DIV);
    localparam logic [TW-1:0]    T_LAST  = TW'(CLK_DIV - 1);
    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

`ifdef DSP_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
`ifdef DSP_UART_PARITY_EN
    logic               parity_q, parity_d;
`endif
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               ovf_q;
    logic [7:0]         mem [DEPTH];
    logic               push, pop, bit_done;
    logic [7:0]         rd_data;
    logic               unused_bus_hi;

    // Only the low byte of the bus carries a character.
    assign unused_bus_hi = ^in[15:8];

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign push     = dsp_in_en && !full;
    assign rd_data  = mem[rd_ptr_q];
    assign bit_done = (timer_q == T_LAST);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= in[7:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A dropped write outranks a clear in the same cycle.
            if (dsp_in_en && full) ovf_q <= 1'b1;
            else if (ovf_clr)      ovf_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef DSP_UART_PARITY_EN
        parity_d = parity_q;
`endif
        if (state_q != IDLE) timer_d = bit_done ? '0 : timer_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = START;
                    timer_d = '0;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
`ifdef DSP_UART_PARITY_EN
                    if (bit_q == 3'd7) state_d = PARITY;
`else
                    if (bit_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef DSP_UART_PARITY_EN
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            shift_d = rd_data;
`ifdef DSP_UART_PARITY_EN
            parity_d = ^rd_data;
`endif
        end

        // tx is registered from the state being entered so it changes exactly on bit boundaries.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef DSP_UART_PARITY_EN
            PARITY:  tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef DSP_UART_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef DSP_UART_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign tx       = tx_q;
    assign busy     = (state_q != IDLE);
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule

// File: doc/dsp_uart_tx.md
Name: dsp_uart_tx

Overview:
Display/console output peripheral. It is the receiving end of the CPU's OUT path: it captures bus words when dsp_in_en is asserted and buffers their low byte in a small FIFO. It then serializes each byte as an 8N1 UART frame on tx. It sits on the shared 16-bit bus next to memory and the register file, and gives the CPU a non-blocking character output.

Parameters:
CLK_DIV, 16, clock cycles per UART bit (minimum 2)
FIFO_AW, 3, FIFO address width; depth = 2**FIFO_AW = 8

Ports:
clk  input  1  system clock; all state on posedge
rst  input  1  asynchronous, active-low reset
in  input  16  shared data bus; valid while dsp_in_en is high
dsp_in_en  input  1  write strobe from controller; sampled on posedge clk
ovf_clr  input  1  synchronous clear of the overflow flag
tx  output  1  UART serial line; idles high
busy  output  1  high while a frame is being shifted (state != IDLE)
full  output  1  FIFO holds 2**FIFO_AW entries
empty  output  1  FIFO holds 0 entries
count  output  FIFO_AW+1  current FIFO occupancy
overflow  output  1  sticky; a write was dropped because the FIFO was full

Behaviour:
- Reset (rst low, asynchronous):
  - tx=1, busy=0, empty=1, full=0, count=0, overflow=0.
  - FSM goes to IDLE; FIFO pointers, bit timer and bit counter clear to 0.
  - Applies immediately, even mid-frame; an aborted frame is not resumed.
- Controller timing: the controller drives dsp_in_en and the bus on negedge. This block samples both on the following posedge.
- Push: on a posedge with dsp_in_en=1 and full=0 (pre-edge value), write in[7:0] at wr_ptr, increment wr_ptr (wraps mod depth), increment count.
- Dropped write: dsp_in_en=1 with full=1 drops the write and sets overflow=1.
  - A pop in the same cycle does not rescue the write; full is judged pre-edge.
- Overflow flag: ovf_clr=1 clears overflow on the next posedge. If a dropped write and ovf_clr occur in the same cycle, set wins.
- Pop: occurs only on the FSM transition into START. It reads the byte at rd_ptr into the shift register and increments rd_ptr (wraps).
- Simultaneous push and pop: count is unchanged.
- Pointers: wr_ptr and rd_ptr are FIFO_AW bits wide. count is maintained separately. full = (count == depth), empty = (count == 0), both combinational from count.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If empty=0, pop and go to START.
  - START: tx=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], each bit held CLK_DIV cycles, LSB first. After 8 bits go to STOP.
  - STOP: tx=1 for CLK_DIV cycles. At the end of STOP:
    - if empty=0, pop and go directly to START (no idle gap);
    - otherwise go to IDLE.
- tx is registered, so it is glitch-free.
- Bit timer: counts 0..CLK_DIV-1 and advances the bit on terminal count.
- Frame length: exactly 10*CLK_DIV cycles.
- Latency: a write at posedge N into an empty FIFO with the FSM in IDLE
  - pops at posedge N+1;
  - drives tx low from posedge N+1 onward.
- Bus bits in[15:8] are ignored.

Optional Feature:
Macro DSP_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles. Frame becomes 8E1, 11*CLK_DIV cycles.
- Undefined: no PARITY state; frames are 8N1, 10*CLK_DIV cycles.

Test Plan:
- Reset then idle: hold rst low 3 cycles, release -> tx=1, empty=1, count=0, busy=0, overflow=0 for 50 cycles.
- Single byte: CLK_DIV=4, write in=16'hAB55 -> tx low 1 cycle after the write edge. Frame bits: 0, 1,0,1,0,1,0,1,0 (0x55 LSB first), 1. Each bit lasts 4 cycles, frame is 40 cycles, high byte ignored.
- Back-to-back: write 0x41, 0x42, 0x43 on consecutive cycles -> count peaks at 2. Three contiguous frames with no gap between STOP and next START. busy stays high for 120 cycles (CLK_DIV=4), then empty=1.
- Overflow: with FSM in STOP, write 9 bytes (0x00..0x08) -> 8 accepted, full=1, overflow=1. Next frames transmit 0x00..0x07. ovf_clr pulse -> overflow=0.
- Reset mid-frame: assert rst during DATA bit 3 of 0xF0 with 2 bytes queued -> tx=1 immediately, count=0. No further frames after release.
- Parity (DSP_UART_PARITY_EN): send 0x07 -> parity bit 1, frame 44 cycles at CLK_DIV=4. Send 0x03 -> parity bit 0.
